// File: rtl/vec_seq_ctrl_unit.sv
// Vector sequencer control unit: decodes one instruction at a time and steps
// it through EXEC, a multi-beat MEM transfer, or a one-cycle jump FLUSH.
module vec_seq_ctrl_unit #(
    parameter int LANES = 4,
    parameter int VLEN  = 16,
    parameter int BW    = ((VLEN / LANES) > 1) ? $clog2(VLEN / LANES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [1:0]    op,
    input  logic [1:0]    inst,
    input  logic          flagV,
    input  logic          mem_ready,
    output logic          ready_in,
    output logic          wmem,
    output logic          rmem,
    output logic          wreg,
    output logic          CondEn,
    output logic          jmpSel,
    output logic          VF,
    output logic [1:0]    jmpF,
    output logic [2:0]    ALUins,
    output logic [1:0]    ExtndSel,
    output logic [BW-1:0] beat_idx,
    output logic          busy,
    output logic          done
);

    localparam int BEATS = VLEN / LANES;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          load_q, load_d;
    logic          wmem_q, wmem_d;
    logic          rmem_q, rmem_d;
    logic          wreg_q, wreg_d;
    logic          cond_q, cond_d;
    logic          jmpsel_q, jmpsel_d;
    logic [1:0]    jmpf_q, jmpf_d;
    logic [2:0]    alu_q, alu_d;
    logic [1:0]    ext_q, ext_d;
    logic          vf_q;

    logic is_store, is_load, jmp_any, jmp_eq, cond_dec, jmp_taken;
    logic accept, last_beat, mem_final;

    // Instruction decode of the word currently offered on op/inst.
    always_comb begin
        is_store  = (op == 2'b01) && (inst == 2'b00);
        is_load   = (op == 2'b11) && (inst == 2'b01);
        jmp_any   = (op == 2'b00) && !inst[1];
        jmp_eq    = (op == 2'b00) && (inst == 2'b01);
        cond_dec  = (op == 2'b01) && (inst != 2'b00);
        jmp_taken = jmp_any && (!jmp_eq || flagV);
        accept    = valid_in && (state_q == S_IDLE);
        last_beat = (beat_q == BW'(BEATS - 1));
        mem_final = (state_q == S_MEM) && mem_ready && last_beat;
    end

    // Next-state and next-strobe logic; one-cycle states clear their strobes on exit.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        load_d   = load_q;
        wmem_d   = wmem_q;
        rmem_d   = rmem_q;
        wreg_d   = 1'b0;
        cond_d   = 1'b0;
        jmpsel_d = 1'b0;
        jmpf_d   = 2'b00;
        alu_d    = 3'b000;
        ext_d    = 2'b00;
        case (state_q)
            S_IDLE: begin
                beat_d = '0;
                wmem_d = 1'b0;
                rmem_d = 1'b0;
                load_d = 1'b0;
                if (accept) begin
                    if (is_store || is_load) begin
                        state_d = S_MEM;
                        wmem_d  = is_store;
                        rmem_d  = is_load;
                        load_d  = is_load;
                    end else if (jmp_taken) begin
                        state_d  = S_FLUSH;
                        jmpf_d   = {jmp_eq, jmp_any};
                        jmpsel_d = 1'b1;
                    end else begin
                        // Includes the not-taken jump-if-equal: every decode term is 0 for it.
                        state_d = S_EXEC;
                        wreg_d  = op[1];
                        cond_d  = cond_dec;
                        alu_d   = (op == 2'b10) ? {1'b0, inst} : 3'b000;
                        ext_d   = (op == 2'b01) ? inst : 2'b00;
                    end
                end
            end
            S_EXEC, S_FLUSH: begin
                state_d = S_IDLE;
            end
            S_MEM: begin
                // mem_ready low is a stall: nothing changes.
                if (mem_ready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                        wmem_d  = 1'b0;
                        rmem_d  = 1'b0;
                        load_d  = 1'b0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and strobe registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            load_q   <= 1'b0;
            wmem_q   <= 1'b0;
            rmem_q   <= 1'b0;
            wreg_q   <= 1'b0;
            cond_q   <= 1'b0;
            jmpsel_q <= 1'b0;
            jmpf_q   <= 2'b00;
            alu_q    <= 3'b000;
            ext_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            load_q   <= load_d;
            wmem_q   <= wmem_d;
            rmem_q   <= rmem_d;
            wreg_q   <= wreg_d;
            cond_q   <= cond_d;
            jmpsel_q <= jmpsel_d;
            jmpf_q   <= jmpf_d;
            alu_q    <= alu_d;
            ext_q    <= ext_d;
        end
    end

    // ALU vector flag is simply delayed one cycle regardless of state.
    always_ff @(posedge clk) begin
        if (rst) vf_q <= 1'b0;
        else     vf_q <= flagV;
    end

    // Retirement and final-beat load write depend on mem_ready in the same
    // cycle, so they are formed here; reset suppresses both.
    always_comb begin
        done = !rst && ((state_q == S_EXEC) || (state_q == S_FLUSH) || mem_final);
        wreg = !rst && (wreg_q || (mem_final && load_q));
    end

    assign ready_in = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign beat_idx = beat_q;
    assign wmem     = wmem_q;
    assign rmem     = rmem_q;
    assign CondEn   = cond_q;
    assign jmpSel   = jmpsel_q;
    assign jmpF     = jmpf_q;
    assign ALUins   = alu_q;
    assign ExtndSel = ext_q;
    assign VF       = vf_q;

endmodule

// File: doc/vec_seq_ctrl_unit.md
VEC_SEQ_CTRL_UNIT -- requirements
Module: vec_seq_ctrl_unit

Interface
REQ-001 Parameter LANES, default 4: vector elements processed per memory beat.
REQ-002 Parameter VLEN, default 16: elements per vector register. VLEN SHALL be a multiple of LANES; BEATS = VLEN/LANES.
REQ-003 Parameter BW, default $clog2(BEATS) (minimum 1): width of beat_idx.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 Ports, in this order:
  - clk, input, 1: rising-edge clock.
  - rst, input, 1: synchronous active-high reset.
  - valid_in, input, 1: instruction on op/inst is valid.
  - op, input, 2: opcode class.
  - inst, input, 2: sub-instruction.
  - flagV, input, 1: ALU vector flag.
  - mem_ready, input, 1: memory accepts/returns the current beat.
  - ready_in, output, 1: unit accepts an instruction this cycle.
  - wmem, rmem, wreg, CondEn, jmpSel, VF, output, 1 each: registered control strobes.
  - jmpF, output, 2: bit 0 = any jump, bit 1 = jump-if-equal.
  - ALUins, output, 3: ALU operation.
  - ExtndSel, output, 2: immediate extend select.
  - beat_idx, output, BW: current memory beat.
  - busy, output, 1: FSM not in IDLE.
  - done, output, 1: one-cycle pulse at instruction retirement.

Function
REQ-006 Decode (c = {op,inst}): store = op==01 & inst==00; load = op==11 & inst==01; wreg_d = op[1]; jmp_any = op==00 & ~inst[1]; jmp_eq = op==00 & inst==01; cond_d = op==01 & inst!=00.
REQ-007 ALUins_d = {1'b0,inst} when op==10, else 3'b000. ExtndSel_d = inst when op==01, else 2'b00.
REQ-008 Accept: an instruction is captured when valid_in & ready_in. ready_in = 1 only in IDLE.
REQ-009 FSM states: IDLE, EXEC, MEM, FLUSH. Encoding is implementer's choice.
REQ-010 IDLE -> MEM on accepted load/store; IDLE -> FLUSH on accepted jump where jmp_any=1 and (jmp_eq=0 or flagV=1); IDLE -> EXEC on any other accepted instruction.
REQ-011 EXEC lasts one cycle:
  - wreg, CondEn, ALUins, ExtndSel driven from captured decode.
  - done=1.
  - Next state IDLE.
REQ-012 MEM behaviour:
  - wmem (store) or rmem (load) held at 1.
  - beat_idx starts at 0 and increments on each cycle with mem_ready=1.
  - mem_ready=0 holds beat_idx and all strobes unchanged (stall).
REQ-013 MEM exit: when mem_ready=1 and beat_idx==BEATS-1, done=1 and next state IDLE; beat_idx returns to 0.
REQ-014 wreg in MEM: for loads, asserted only on the final accepted beat; always 0 for stores.
REQ-015 FLUSH lasts one cycle:
  - jmpF and jmpSel = jmpF[1]|jmpF[0] asserted.
  - wreg=0, wmem=0, rmem=0.
  - done=1.
  - Next state IDLE.
REQ-016 Not-taken jump-if-equal (flagV=0) goes to EXEC with all strobes 0 and jmpSel=0. It retires with done=1.
REQ-017 VF is flagV registered every cycle, independent of state.
REQ-018 Outside the state that drives them, all strobes, jmpF, ALUins and ExtndSel SHALL be 0.
REQ-019 Latency: one instruction in flight at a time.
  - Non-memory instruction: 1 cycle from accept to done.
  - Memory instruction: BEATS cycles plus stall cycles.
REQ-020 valid_in while busy is ignored. The upstream source must hold the instruction until ready_in=1.

Reset
REQ-021 rst=1 at a clock edge forces IDLE and beat_idx=0. All outputs go to 0 on that edge, except ready_in, which is 1.
REQ-022 rst mid-MEM abandons the transfer: no done pulse, no wreg. The next cycle after rst deasserts accepts a new instruction.
REQ-023 rst has priority over valid_in and mem_ready in the same cycle.

Verification
REQ-024 Reset: hold rst 2 cycles -> all strobes 0, ready_in=1, busy=0, beat_idx=0.
REQ-025 Store, LANES=4, VLEN=16, mem_ready=1 constant: op=01, inst=00 -> wmem=1 for 4 cycles, beat_idx 0,1,2,3, done on 4th cycle, wreg never 1.
REQ-026 Load with stalls: op=11, inst=01, mem_ready low for 2 cycles at beat 1 -> rmem=1 for 6 cycles, beat_idx sequence 0,1,1,1,2,3, wreg=1 only on final beat.
REQ-027 Jump-if-equal: op=00, inst=01.
  - flagV=1 -> FLUSH: jmpF=11, jmpSel=1, wreg=0.
  - flagV=0 -> jmpSel=0, done after 1 cycle.
REQ-028 Back-to-back and reset: valid_in held high during a load -> second instruction captured only after done.
  - rst asserted at beat 2 -> IDLE next cycle, no done pulse.
  - Then ALU op=10, inst=11 -> ALUins=011, wreg=1 for 1 cycle.
